// File: rtl/dmem_pkg.sv
// Purpose : shared constants and lane helpers for the DMEM responder.
// Latency : n/a (package only).
// Backpressure: n/a.
package dmem_pkg;

  // RV32 load/store size field encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // MMIO register byte addresses
  localparam logic [9:0] LED_ADDR = 10'h3F0;
  localparam logic [9:0] CNT_ADDR = 10'h3F4;

  // Which source drives the load data output
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_MMIO = 2'd2
  } rsp_src_e;

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  lo,
                                               input logic [2:0]  f3);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {lo, 3'b000};
    case (f3)
      F3_B:    r = {{24{sh[7]}}, sh[7:0]};
      F3_H:    r = {{16{sh[15]}}, sh[15:0]};
      F3_W:    r = w;
      F3_BU:   r = {24'h0, sh[7:0]};
      F3_HU:   r = {16'h0, sh[15:0]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Byte enables for a store of the given size at the given lane offset.
  function automatic logic [3:0] byte_en(input logic [1:0] lo,
                                         input logic [2:0] f3);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lo;
      F3_H:    be = lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Purpose : single-port word RAM with per-byte write enables.
// Latency : read data registered, valid the cycle after re; write at the edge.
// Backpressure: none; one access per cycle.
// Ports   : CLK, we/be/wdata (write), re (read), idx (word index), rdata.
module dmem_ram #(
  parameter int DEPTH = 252,
  parameter int IDX_W = 8
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // rdata only moves on a read, so it holds between loads
  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Purpose : DMEM port responder: byte-addressed RAM plus LED / cycle-counter MMIO.
// Latency : load data and error flag presented one cycle after the request.
// Backpressure: none; a request may be issued every cycle.
// Ports   : CLK, RST (sync, active high), MemRead/MemWrite/address_DMEM/
//           write_data_DMEM/funct3 (request), data_DMEM/resp_valid/misaligned
//           (response), led (MMIO LED register).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int              ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 10'h3F0,
  parameter int              LED_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] address_DMEM,
  input  logic [31:0]       write_data_DMEM,
  input  logic [2:0]        funct3,
  output logic [31:0]       data_DMEM,
  output logic              resp_valid,
  output logic              misaligned,
  output logic [LED_W-1:0]  led
);

  localparam int RAM_DEPTH = int'(MMIO_BASE) / 4;
  localparam logic [ADDR_W-1:0] LED_A = ADDR_W'(LED_ADDR);
  localparam logic [ADDR_W-1:0] CNT_A = ADDR_W'(CNT_ADDR);

  logic        is_store, is_load, is_mmio;
  logic        illegal, unaligned, err;
  logic        ram_we, ram_re, led_we, cnt_clr;
  logic [1:0]  lo;
  logic [31:0] wlanes, mmio_val, ram_rdata, cnt;

  // response-side state, captured only when a load is accepted
  rsp_src_e    src_q;
  logic [1:0]  lo_q;
  logic [2:0]  f3_q;
  logic [31:0] mmio_q;

  assign lo       = address_DMEM[1:0];
  assign is_store = MemWrite;               // store wins when both strobes are high
  assign is_load  = MemRead & ~MemWrite;
  assign is_mmio  = address_DMEM >= MMIO_BASE;

  always_comb begin
    illegal   = 1'b0;
    unaligned = 1'b0;
    wlanes    = write_data_DMEM;
    mmio_val  = 32'h0;
    if (is_store) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else          illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    if ((funct3 == F3_H || funct3 == F3_HU) && lo[0]) unaligned = 1'b1;
    if (funct3 == F3_W && lo != 2'b00)               unaligned = 1'b1;
    // MMIO is word-only; any other size counts as an alignment error
    if (is_mmio && funct3 != F3_W)                   unaligned = 1'b1;
    // replicate store data across lanes so byte enables select the right copy
    case (funct3)
      F3_B:    wlanes = {4{write_data_DMEM[7:0]}};
      F3_H:    wlanes = {2{write_data_DMEM[15:0]}};
      default: wlanes = write_data_DMEM;
    endcase
    if (address_DMEM == LED_A)      mmio_val = 32'(led);
    else if (address_DMEM == CNT_A) mmio_val = cnt;
  end

  assign err     = (is_store | is_load) & (illegal | unaligned);
  assign ram_we  = is_store & ~err & ~is_mmio;
  assign ram_re  = is_load  & ~err & ~is_mmio;
  assign led_we  = is_store & ~err & (address_DMEM == LED_A);
  assign cnt_clr = is_store & ~err & (address_DMEM == CNT_A);

  dmem_ram #(
    .DEPTH (RAM_DEPTH),
    .IDX_W (ADDR_W-2)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .be    (byte_en(lo, funct3)),
    .re    (ram_re),
    .idx   (address_DMEM[ADDR_W-1:2]),
    .wdata (wlanes),
    .rdata (ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      resp_valid <= 1'b0;
      misaligned <= 1'b0;
      led        <= '0;
      cnt        <= 32'h0;
      src_q      <= SRC_ZERO;
      lo_q       <= 2'b00;
      f3_q       <= F3_W;
      mmio_q     <= 32'h0;
    end else begin
      resp_valid <= is_load;
      misaligned <= err;
      if (led_we) led <= write_data_DMEM[LED_W-1:0];
      cnt <= cnt_clr ? 32'h0 : cnt + 32'd1;
      if (is_load) begin
        lo_q   <= lo;
        f3_q   <= funct3;
        mmio_q <= mmio_val;
        if (err)          src_q <= SRC_ZERO;
        else if (is_mmio) src_q <= SRC_MMIO;
        else              src_q <= SRC_RAM;
      end
    end
  end

  always_comb begin
    data_DMEM = 32'h0;
    case (src_q)
      SRC_RAM:  data_DMEM = load_extract(ram_rdata, lo_q, f3_q);
      SRC_MMIO: data_DMEM = mmio_q;
      default:  data_DMEM = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemRead, MemWrite;
  logic [9:0]  address_DMEM;
  logic [31:0] write_data_DMEM;
  logic [2:0]  funct3;
  logic [31:0] data_DMEM;
  logic        resp_valid, misaligned;
  logic [7:0]  led;

  int nvec = 0;
  int nerr = 0;
  int nreq = 0;

  typedef struct {
    int          id;
    logic        v;
    logic        m;
    logic        chk;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];

  always #5 CLK = ~CLK;

  dmem_responder dut (
    .CLK             (CLK),
    .RST             (RST),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .address_DMEM    (address_DMEM),
    .write_data_DMEM (write_data_DMEM),
    .funct3          (funct3),
    .data_DMEM       (data_DMEM),
    .resp_valid      (resp_valid),
    .misaligned      (misaligned),
    .led             (led)
  );

  // One request cycle: drive at negedge, record the response expected after the next posedge.
  task automatic cyc(input logic rst, input logic rd, input logic wr,
                     input logic [9:0] a, input logic [31:0] wd, input logic [2:0] f3,
                     input logic ev, input logic em, input logic chk, input logic [31:0] ed);
    exp_t e;
    @(negedge CLK);
    RST = rst; MemRead = rd; MemWrite = wr;
    address_DMEM = a; write_data_DMEM = wd; funct3 = f3;
    e.id = nreq; e.v = ev; e.m = em; e.chk = chk; e.d = ed;
    q.push_back(e);
    nreq++;
  endtask

  task automatic idle(input logic chk, input logic [31:0] ed);
    cyc(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 3'b010, 1'b0, 1'b0, chk, ed);
  endtask

  task automatic ld(input logic [9:0] a, input logic [2:0] f3, input logic em, input logic [31:0] ed);
    cyc(1'b0, 1'b1, 1'b0, a, 32'h0, f3, 1'b1, em, 1'b1, ed);
  endtask

  task automatic st(input logic [9:0] a, input logic [31:0] wd, input logic [2:0] f3, input logic em);
    cyc(1'b0, 1'b0, 1'b1, a, wd, f3, 1'b0, em, 1'b0, 32'h0);
  endtask

  // Checks the LED register just after the edge that samples the current request.
  task automatic check_led(input logic [7:0] exp);
    @(posedge CLK);
    #2;
    nvec++;
    if (led !== exp) begin
      nerr++;
      $display("FAIL led got %h want %h", led, exp);
    end
  endtask

  // Monitor: pops one expectation per clock edge and compares the response.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        nvec++;
        if (resp_valid !== e.v) begin
          nerr++;
          $display("FAIL rsp#%0d resp_valid got %b want %b", e.id, resp_valid, e.v);
        end
        nvec++;
        if (misaligned !== e.m) begin
          nerr++;
          $display("FAIL rsp#%0d misaligned got %b want %b", e.id, misaligned, e.m);
        end
        if (e.chk) begin
          nvec++;
          if (data_DMEM !== e.d) begin
            nerr++;
            $display("FAIL rsp#%0d data_DMEM got %h want %h", e.id, data_DMEM, e.d);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    address_DMEM = '0; write_data_DMEM = '0; funct3 = 3'b010;

    // reset: everything zero
    cyc(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1, 32'h0);
    check_led(8'h00);

    // word store/load and sub-word extraction
    st(10'h010, 32'hDEADBEEF, 3'b010, 1'b0);
    ld(10'h010, 3'b010, 1'b0, 32'hDEADBEEF);
    ld(10'h013, 3'b000, 1'b0, 32'hFFFFFFDE);
    ld(10'h013, 3'b100, 1'b0, 32'h000000DE);
    ld(10'h012, 3'b001, 1'b0, 32'hFFFFDEAD);
    ld(10'h010, 3'b101, 1'b0, 32'h0000BEEF);
    idle(1'b1, 32'h0000BEEF);                    // data holds while not valid

    // partial stores, each immediately followed by a load of the same word
    st(10'h011, 32'h00000055, 3'b000, 1'b0);
    ld(10'h010, 3'b010, 1'b0, 32'hDEAD55EF);
    st(10'h012, 32'h00001234, 3'b001, 1'b0);
    ld(10'h010, 3'b010, 1'b0, 32'h123455EF);

    // alignment / illegal size
    ld(10'h011, 3'b001, 1'b1, 32'h0);
    st(10'h012, 32'hFFFFFFFF, 3'b010, 1'b1);
    ld(10'h010, 3'b010, 1'b0, 32'h123455EF);
    ld(10'h010, 3'b011, 1'b1, 32'h0);
    st(10'h010, 32'h00000000, 3'b100, 1'b1);     // no unsigned store
    ld(10'h010, 3'b010, 1'b0, 32'h123455EF);

    // last RAM word
    st(10'h3EC, 32'hCAFEF00D, 3'b010, 1'b0);
    ld(10'h3EC, 3'b010, 1'b0, 32'hCAFEF00D);
    ld(10'h3EF, 3'b100, 1'b0, 32'h000000CA);

    // MMIO LED
    st(10'h3F0, 32'h000001A5, 3'b010, 1'b0);
    check_led(8'hA5);
    ld(10'h3F0, 3'b000, 1'b1, 32'h0);
    check_led(8'hA5);
    ld(10'h3F0, 3'b010, 1'b0, 32'h000000A5);
    cyc(1'b0, 1'b1, 1'b1, 10'h3F0, 32'h0000003C, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
    check_led(8'h3C);

    // reserved MMIO words
    ld(10'h3F8, 3'b010, 1'b0, 32'h0);
    st(10'h3FC, 32'h12345678, 3'b010, 1'b0);
    ld(10'h3FC, 3'b010, 1'b0, 32'h0);

    // cycle counter: clear at t, read at t+5 sees 4
    st(10'h3F4, 32'h0000FFFF, 3'b010, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0, 32'h0);
    ld(10'h3F4, 3'b010, 1'b0, 32'h00000004);

    // reset drops the pending load, clears led and counter
    ld(10'h010, 3'b010, 1'b0, 32'h123455EF);
    cyc(1'b1, 1'b1, 1'b0, 10'h010, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1, 32'h0);
    check_led(8'h00);
    ld(10'h3F4, 3'b010, 1'b0, 32'h00000000);
    ld(10'h3F4, 3'b010, 1'b0, 32'h00000001);
    ld(10'h010, 3'b010, 1'b0, 32'h123455EF);    // RAM survives reset

    idle(1'b0, 32'h0);
    idle(1'b0, 32'h0);
    repeat (3) @(posedge CLK);
    #3;
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
